// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter.
//   arb_state_e : burst FSM states (IDLE, BURST); the FSM exists only when
//                 FIFO_ARB_BURST_EN is defined.
//   ptr_width   : bits needed for a requester index / round-robin pointer.
//   occ_width   : bits needed to count 0..DEPTH committed words.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int unsigned ptr_width(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester / FIFO-write bundle for fifo_wr_arbiter.
//   req, data_in  : requester requests and their words (slice i = [i*WIDTH +: WIDTH])
//   gnt           : combinational one-hot (or zero) grant
//   fifo_write,
//   fifo_wdata    : registered FIFO write port
//   fifo_read     : consumer read strobe, observed by the arbiter
//   occupancy,
//   full          : committed word count and registered full flag
// Modports: master = requesters/consumer side, slave = arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned OW = occ_width(DEPTH);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_write;
  logic [WIDTH-1:0]      fifo_wdata;
  logic                  fifo_read;
  logic [OW-1:0]         occupancy;
  logic                  full;

  modport master (
    output req, data_in, fifo_read,
    input  gnt, fifo_write, fifo_wdata, occupancy, full
  );

  modport slave (
    input  req, data_in, fifo_read,
    output gnt, fifo_write, fifo_wdata, occupancy, full
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   req_i : request vector
//   ptr_i : index with highest priority; search wraps from NREQ-1 to 0
//   gnt_o : one-hot grant of the first set request at or after ptr_i (zero if none)
//   idx_o : index of that request (zero if none)
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);
  always_comb begin
    int unsigned j;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr_i) + i) % NREQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter in front of a shared synchronous FIFO.
// Accepts at most one requester word per clock, registers it onto the FIFO
// write port and tracks occupancy locally so it never writes a full FIFO.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (also resets the FIFO)
//   bus   : fifo_wr_arbiter_if.slave (req/data_in/gnt, FIFO write port,
//           fifo_read observation, occupancy, full)
// Build option: define FIFO_ARB_BURST_EN to enable the IDLE/BURST FSM that
// lets a granted owner keep priority for up to MAX_BURST consecutive words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int unsigned PW = ptr_width(NREQ);
  localparam int unsigned OW = occ_width(DEPTH);

  if (NREQ < 2 || MAX_BURST < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: NREQ must be >= 2 and MAX_BURST >= 1");
  end

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             full_q, full_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic [NREQ-1:0]  gnt_c;
  logic [PW-1:0]    gidx;
  logic             grant;
  logic             space;
  logic             rd_ok;
  logic [WIDTH-1:0] wsel;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  arb_state_e       state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             keep;
`endif

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign space = (occ_q < OW'(DEPTH));
  // A read only retires a word the FIFO actually holds; the word written
  // this cycle is not yet readable.
  assign rd_ok = bus.fifo_read && (occ_q > OW'(wr_q));

  always_comb begin
    gnt_c = '0;
    gidx  = '0;
    grant = 1'b0;
`ifdef FIFO_ARB_BURST_EN
    keep = (state_q == BURST) && bus.req[owner_q] &&
           (bcnt_q < BW'(MAX_BURST)) && space;
    if (keep) begin
      gnt_c[owner_q] = 1'b1;
      gidx           = owner_q;
      grant          = 1'b1;
    end else if (space && (|bus.req)) begin
      gnt_c = pick_gnt;
      gidx  = pick_idx;
      grant = 1'b1;
    end
`else
    if (space && (|bus.req)) begin
      gnt_c = pick_gnt;
      gidx  = pick_idx;
      grant = 1'b1;
    end
`endif
  end

  always_comb begin
    wsel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx == PW'(i)) wsel = bus.data_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    wr_d    = grant;
    wdata_d = wdata_q;
    occ_d   = occ_q;
    if (grant) begin
      ptr_d   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
      wdata_d = wsel;
    end
    case ({grant, rd_ok})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    full_d = (occ_d == OW'(DEPTH));
  end

`ifdef FIFO_ARB_BURST_EN
  // Every grant (re)opens a burst for its receiver; a burst that ends with a
  // grant to someone else therefore hands straight over without an idle cycle.
  always_comb begin
    state_d = grant ? BURST : IDLE;
    owner_d = grant ? gidx : owner_q;
    if (keep)       bcnt_d = bcnt_q + BW'(1);
    else if (grant) bcnt_d = BW'(1);
    else            bcnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      occ_q   <= '0;
      full_q  <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      occ_q   <= occ_d;
      full_q  <= full_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.gnt        = rst_n ? gnt_c : '0;
  assign bus.fifo_write = wr_q;
  assign bus.fifo_wdata = wdata_q;
  assign bus.occupancy  = occ_q;
  assign bus.full       = full_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, WIDTH=4, DEPTH=8,
// MAX_BURST=4). Expectations follow FIFO_ARB_BURST_EN when it is defined.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(4), .WIDTH(4), .DEPTH(8)) bus ();

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(4), .DEPTH(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.data_in = '0;
    bus.fifo_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.req = 4'b1111; bus.data_in = 16'h4321; bus.fifo_read = 1'b0;
    rst_n = 1'b0;
    #2;
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL reset0_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.fifo_write !== 1'b0) begin n_err++; $display("FAIL reset0_write: got %b want 0", bus.fifo_write); end
    n_cmp++; if (bus.fifo_wdata !== 4'h0) begin n_err++; $display("FAIL reset0_wdata: got %h want 0", bus.fifo_wdata); end
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    n_cmp++; if (bus.occupancy !== 4'd5) begin n_err++; $display("FAIL fill5_occ: got %0d want 5", bus.occupancy); end
    n_cmp++; if (bus.fifo_write !== 1'b1) begin n_err++; $display("FAIL fill5_write: got %b want 1", bus.fifo_write); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL midreset_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.fifo_write !== 1'b0) begin n_err++; $display("FAIL midreset_write: got %b want 0", bus.fifo_write); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL midreset_occ: got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL midreset_full: got %b want 0", bus.full); end
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL post_reset_gnt: got %b want 0001", bus.gnt); end
  endtask

  task automatic test_single_word();
    do_reset();
    bus.req = 4'b0100; bus.data_in = 16'h3A21;
    #1;
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
    tick();
    bus.req = 4'b0000;
    n_cmp++; if (bus.fifo_write !== 1'b1) begin n_err++; $display("FAIL single_write: got %b want 1", bus.fifo_write); end
    n_cmp++; if (bus.fifo_wdata !== 4'hA) begin n_err++; $display("FAIL single_wdata: got %h want a", bus.fifo_wdata); end
    n_cmp++; if (bus.occupancy !== 4'd1) begin n_err++; $display("FAIL single_occ: got %0d want 1", bus.occupancy); end
    tick();
    n_cmp++; if (bus.fifo_write !== 1'b0) begin n_err++; $display("FAIL single_idle_write: got %b want 0", bus.fifo_write); end
    n_cmp++; if (bus.fifo_wdata !== 4'hA) begin n_err++; $display("FAIL single_hold_wdata: got %h want a", bus.fifo_wdata); end
  endtask

  task automatic test_fairness_to_full();
    logic [15:0] dv;
    logic [3:0]  exp_g;
    logic [3:0]  exp_d;
    int          k;
    do_reset();
    dv = 16'hC5A3;
    bus.req = 4'b1111; bus.data_in = dv;
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_ARB_BURST_EN
      k = i / 4;
`else
      k = i % 4;
`endif
      exp_g = 4'b0001 << k;
      exp_d = dv[k*4 +: 4];
      #1;
      n_cmp++; if (bus.gnt !== exp_g) begin n_err++; $display("FAIL fair_gnt[%0d]: got %b want %b", i, bus.gnt, exp_g); end
      tick();
      n_cmp++; if (bus.fifo_write !== 1'b1) begin n_err++; $display("FAIL fair_write[%0d]: got %b want 1", i, bus.fifo_write); end
      n_cmp++; if (bus.fifo_wdata !== exp_d) begin n_err++; $display("FAIL fair_wdata[%0d]: got %h want %h", i, bus.fifo_wdata, exp_d); end
    end
    n_cmp++; if (bus.occupancy !== 4'd8) begin n_err++; $display("FAIL fair_occ: got %0d want 8", bus.occupancy); end
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fair_full: got %b want 1", bus.full); end
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL fair_full_gnt: got %b want 0000", bus.gnt); end
    tick();
    n_cmp++; if (bus.fifo_write !== 1'b0) begin n_err++; $display("FAIL full_write: got %b want 0", bus.fifo_write); end
    n_cmp++; if (bus.occupancy !== 4'd8) begin n_err++; $display("FAIL full_hold_occ: got %0d want 8", bus.occupancy); end
  endtask

  // Continues from the full FIFO left by test_fairness_to_full.
  task automatic test_drain_full();
    logic [3:0] exp_g;
`ifdef FIFO_ARB_BURST_EN
    exp_g = 4'b0100;
`else
    exp_g = 4'b0001;
`endif
    bus.fifo_read = 1'b1;
    #1;
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL drain_read_gnt: got %b want 0000", bus.gnt); end
    tick();
    bus.fifo_read = 1'b0;
    n_cmp++; if (bus.occupancy !== 4'd7) begin n_err++; $display("FAIL drain_occ: got %0d want 7", bus.occupancy); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL drain_full: got %b want 0", bus.full); end
    #1;
    n_cmp++; if (bus.gnt !== exp_g) begin n_err++; $display("FAIL drain_regrant: got %b want %b", bus.gnt, exp_g); end
    tick();
    bus.req = 4'b0000;
    n_cmp++; if (bus.occupancy !== 4'd8) begin n_err++; $display("FAIL refill_occ: got %0d want 8", bus.occupancy); end
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL refill_full: got %b want 1", bus.full); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.req = 4'b0001; bus.data_in = 16'h0007;
    repeat (3) tick();
    n_cmp++; if (bus.occupancy !== 4'd3) begin n_err++; $display("FAIL simul_pre_occ: got %0d want 3", bus.occupancy); end
    bus.fifo_read = 1'b1;
    #1;
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL simul_gnt: got %b want 0001", bus.gnt); end
    tick();
    bus.req = 4'b0000; bus.fifo_read = 1'b0;
    n_cmp++; if (bus.occupancy !== 4'd3) begin n_err++; $display("FAIL simul_occ: got %0d want 3", bus.occupancy); end
    // read with nothing stored while a write is in flight
    do_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000; bus.fifo_read = 1'b1;
    tick();
    n_cmp++; if (bus.occupancy !== 4'd1) begin n_err++; $display("FAIL stored0_occ: got %0d want 1", bus.occupancy); end
    // read from an empty FIFO must not underflow
    do_reset();
    bus.fifo_read = 1'b1;
    tick();
    bus.fifo_read = 1'b0;
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL empty_read_occ: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_burst();
    logic [3:0] exp_g;
    int         k;
    do_reset();
    bus.req = 4'b0011; bus.data_in = 16'h00B6;
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_ARB_BURST_EN
      k = i / 4;
`else
      k = i % 2;
`endif
      exp_g = 4'b0001 << k;
      #1;
      n_cmp++; if (bus.gnt !== exp_g) begin n_err++; $display("FAIL burst_gnt[%0d]: got %b want %b", i, bus.gnt, exp_g); end
      tick();
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    bus.req = '0; bus.data_in = '0; bus.fifo_read = 1'b0;
    #1;
    test_reset();
    test_single_word();
    test_fairness_to_full();
    test_drain_full();
    test_simultaneous();
    test_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
